// File: rtl/alu_muldiv.sv
`timescale 1ns/1ps
// Execute-stage ALU: RV32I base ops plus RV32M multiply/divide behind a valid/ready pair.
// Latency: base ops and special divides 1 cycle, MUL* 2 cycles, DIV/REM XLEN/DIV_BITS+2 cycles.
// Backpressure: the result is held in DONE until out_ready; in_ready only while idle or draining.
// Ports: clk, rst_n (async, active-low), flush (abort op in flight);
//        in_valid/in_ready + op/src_a/src_b (input handshake);
//        out_valid/out_ready + result/zero_flag/neg_flag (output handshake); busy = not idle.
module alu_muldiv #(
    parameter int XLEN     = 32,
    parameter int DIV_BITS = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      op,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero_flag,
    output logic            neg_flag,
    output logic            busy
);
    localparam int DIV_CYC = XLEN / DIV_BITS;
    localparam int CNT_W   = $clog2(DIV_CYC + 1);
    localparam int SH_W    = $clog2(XLEN);

    localparam logic [4:0] OP_ADD  = 5'd0,  OP_SUB  = 5'd1,  OP_SLL    = 5'd2,  OP_SLT   = 5'd3;
    localparam logic [4:0] OP_SLTU = 5'd4,  OP_XOR  = 5'd5,  OP_OR     = 5'd6,  OP_AND   = 5'd7;
    localparam logic [4:0] OP_SRL  = 5'd8,  OP_SRA  = 5'd9,  OP_MUL    = 5'd10, OP_MULH  = 5'd11;
    localparam logic [4:0] OP_MULHSU = 5'd12, OP_DIV = 5'd14, OP_REM   = 5'd16, OP_REMU  = 5'd17;

    typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

    state_t            state, state_nx;
    logic [4:0]        op_r;
    logic [XLEN-1:0]   opa_r;     // multiplicand, or dividend magnitude shifting into quotient
    logic [XLEN-1:0]   opb_r;     // multiplier, or divisor magnitude
    logic [XLEN-1:0]   rem_r;
    logic [CNT_W-1:0]  cnt;
    logic              neg_q_r, neg_r_r;

    logic              accept;
    logic              is_mul, is_div, is_rem, div_signed, a_neg, b_neg, div_zero, div_ovf;
    logic [XLEN-1:0]   abs_a, abs_b, alu_res, spec_res;
    logic [SH_W-1:0]   shamt;
    state_t            accept_target;

    // ---------------- input-side decode ----------------
    assign accept     = in_valid && in_ready && !flush;
    assign is_mul     = op inside {[5'd10:5'd13]};
    assign is_div     = op inside {[5'd14:5'd17]};
    assign is_rem     = (op == OP_REM) || (op == OP_REMU);
    assign div_signed = (op == OP_DIV) || (op == OP_REM);
    assign a_neg      = div_signed && src_a[XLEN-1];
    assign b_neg      = div_signed && src_b[XLEN-1];
    // For non-signed-divide ops these pass the raw operands, which the multiplier reuses.
    assign abs_a      = a_neg ? -src_a : src_a;
    assign abs_b      = b_neg ? -src_b : src_b;
    assign div_zero   = (src_b == '0);
    assign div_ovf    = div_signed && (src_a == {1'b1, {(XLEN-1){1'b0}}}) && (src_b == '1);
    assign spec_res   = div_zero ? (is_rem ? src_a : '1) : (is_rem ? '0 : src_a);
    assign shamt      = src_b[SH_W-1:0];

    always_comb begin
        if (is_mul)                                  accept_target = S_MUL;
        else if (is_div && !div_zero && !div_ovf)    accept_target = S_DIV;
        else                                         accept_target = S_DONE;
    end

    always_comb begin
        alu_res = '0;
        case (op)
            OP_ADD:  alu_res = src_a + src_b;
            OP_SUB:  alu_res = src_a - src_b;
            OP_SLL:  alu_res = src_a << shamt;
            OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(src_a) < $signed(src_b)};
            OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, src_a < src_b};
            OP_XOR:  alu_res = src_a ^ src_b;
            OP_OR:   alu_res = src_a | src_b;
            OP_AND:  alu_res = src_a & src_b;
            OP_SRL:  alu_res = src_a >> shamt;
            OP_SRA:  alu_res = $signed(src_a) >>> shamt;
            default: alu_res = '0;   // mul/div handled elsewhere; 18-31 yield zero
        endcase
    end

    // ---------------- multiplier ----------------
    // Sign-extend to 2*XLEN; the wrapped product is exact for the low 2*XLEN bits.
    logic              mul_sa, mul_sb;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   mul_res;
    assign mul_sa  = ((op_r == OP_MULH) || (op_r == OP_MULHSU)) && opa_r[XLEN-1];
    assign mul_sb  = (op_r == OP_MULH) && opb_r[XLEN-1];
    assign prod    = {{XLEN{mul_sa}}, opa_r} * {{XLEN{mul_sb}}, opb_r};
    assign mul_res = (op_r == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

    // ---------------- restoring divider step ----------------
    // rem < divisor always holds, so the XLEN+1-bit trial difference never overflows.
    logic [XLEN-1:0] rem_nx, quo_nx, fix_q, fix_r, fix_res;
    logic [XLEN:0]   trial;
    always_comb begin
        rem_nx = rem_r;
        quo_nx = opa_r;
        trial  = '0;
        for (int i = 0; i < DIV_BITS; i++) begin
            trial = {rem_nx, quo_nx[XLEN-1]} - {1'b0, opb_r};
            if (!trial[XLEN]) begin
                rem_nx = trial[XLEN-1:0];
                quo_nx = {quo_nx[XLEN-2:0], 1'b1};
            end else begin
                rem_nx = {rem_nx[XLEN-2:0], quo_nx[XLEN-1]};
                quo_nx = {quo_nx[XLEN-2:0], 1'b0};
            end
        end
    end
    assign fix_q   = neg_q_r ? -opa_r : opa_r;
    assign fix_r   = neg_r_r ? -rem_r : rem_r;
    assign fix_res = ((op_r == OP_REM) || (op_r == OP_REMU)) ? fix_r : fix_q;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (flush) begin
            state_nx = S_IDLE;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (accept)                             state_nx = accept_target;
                    else if (state == S_DONE && out_ready)  state_nx = S_IDLE;
                end
                S_MUL:   state_nx = S_DONE;
                S_DIV:   if (cnt == CNT_W'(DIV_CYC - 1)) state_nx = S_FIX;
                S_FIX:   state_nx = S_DONE;
                default: state_nx = S_IDLE;
            endcase
        end
    end

    always_comb begin
        in_ready  = (state == S_IDLE) || (state == S_DONE && out_ready);
        out_valid = (state == S_DONE);
        busy      = (state != S_IDLE);
        zero_flag = (result == '0);
        neg_flag  = result[XLEN-1];
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_r    <= '0;
            opa_r   <= '0;
            opb_r   <= '0;
            rem_r   <= '0;
            cnt     <= '0;
            neg_q_r <= 1'b0;
            neg_r_r <= 1'b0;
            result  <= '0;
        end else if (accept) begin
            op_r    <= op;
            opa_r   <= abs_a;
            opb_r   <= abs_b;
            rem_r   <= '0;
            cnt     <= '0;
            neg_q_r <= a_neg ^ b_neg;
            neg_r_r <= a_neg;
            if (is_div) begin
                if (div_zero || div_ovf) result <= spec_res;
            end else if (!is_mul) begin
                result <= alu_res;
            end
        end else if (!flush) begin
            case (state)
                S_MUL: result <= mul_res;
                S_DIV: begin
                    opa_r <= quo_nx;
                    rem_r <= rem_nx;
                    cnt   <= cnt + 1'b1;
                end
                S_FIX: result <= fix_res;
                default: ;
            endcase
        end
    end
endmodule
